// File: rtl/s2mm_pkg.sv
// Shared defaults, types and the bank-index helper for the double-buffered
// stream-to-memory loader.
package s2mm_pkg;

  localparam int DEF_D_W   = 8;
  localparam int DEF_PACK  = 2;
  localparam int DEF_N     = 4;
  localparam int DEF_DEPTH = 1024;
  localparam int DEF_ADDR_W = $clog2(DEF_DEPTH);

  typedef logic [DEF_ADDR_W:0]        bank_addr_t;
  typedef logic signed [DEF_D_W-1:0]  elem_t;

  function automatic int unsigned bank_of(input int unsigned idx, input int unsigned n);
    return idx % n;
  endfunction

endpackage

// File: rtl/s2mm_bank_ram.sv
// Simple-dual-port bank RAM: one write port, one registered read port that
// returns zero on cycles without a read request.
module s2mm_bank_ram #(
  parameter int D_W    = 8,
  parameter int AW     = 11,
  parameter int DEPTH2 = 2048
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [D_W-1:0] wd,
  input  logic          re,
  input  logic [AW-1:0] ra,
  output logic [D_W-1:0] q
);

  logic [D_W-1:0] mem [DEPTH2];

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wa] <= wd;
    end
  end

  // Registered read port, zero when idle
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= {D_W{1'b0}};
    end else if (re) begin
      q <= mem[ra];
    end else begin
      q <= {D_W{1'b0}};
    end
  end

endmodule

// File: rtl/s2mm_pingpong.sv
// Ping-pong stream-to-memory loader: scatters packed beats across N bank RAMs.
// Optional batch length checking is enabled with `define S2MM_PP_LEN_CHECK_EN.
module s2mm_pingpong
  import s2mm_pkg::*;
#(
  parameter int D_W          = DEF_D_W,
  parameter int PACK         = DEF_PACK,
  parameter int N            = DEF_N,
  parameter int DEPTH        = DEF_DEPTH,
  parameter int ADDR_W       = $clog2(DEPTH),
  parameter int MATRIXSIZE_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [PACK*D_W-1:0]     s_axis_s2mm_tdata,
  input  logic                    s_axis_s2mm_tvalid,
  input  logic                    s_axis_s2mm_tlast,
  output logic                    s_axis_s2mm_tready,
  input  logic [MATRIXSIZE_W-1:0] batch_beats,
  output logic                    start_multiply,
  input  logic                    done_multiply,
  input  logic                    rd_en,
  input  logic [ADDR_W-1:0]       rd_addr,
  output logic signed [D_W-1:0]   rd_data [N],
  output logic                    rd_valid,
  output logic [1:0]              buf_full,
  output logic                    len_err
);

  logic                    wbuf_r, rbuf_r, rst_d_r;
  logic [1:0]              full_r;
  logic [MATRIXSIZE_W-1:0] beat_cnt_r;
  logic                    wr_valid_r, wr_last_r, wr_buf_r;
  logic [ADDR_W:0]         wr_addr_r;
  logic [PACK*D_W-1:0]     wr_data_r;
  logic [31:0]             wr_base_r;
  logic                    commit_r, commit_buf_r;
  logic                    len_err_r, rd_valid_r;

  logic        accept_s, pend_s, release_s, is_last_s, len_mis_s, ovf_s;
  logic [31:0] elem_idx_s, row_s;
  logic [1:0]  set_s, clr_s;

  assign elem_idx_s = 32'(beat_cnt_r) * 32'(PACK);
  assign row_s      = elem_idx_s / 32'(N);
  assign ovf_s      = row_s >= 32'(DEPTH);

  // A buffer whose last write is still committing is not yet marked full
  assign pend_s    = commit_r && (commit_buf_r == wbuf_r);
  assign s_axis_s2mm_tready = !full_r[wbuf_r] && !rst_d_r && !rst && !pend_s;
  assign accept_s  = s_axis_s2mm_tvalid && s_axis_s2mm_tready;
  assign release_s = done_multiply && full_r[rbuf_r];
  assign set_s     = commit_r  ? (2'b01 << commit_buf_r) : 2'b00;
  assign clr_s     = release_s ? (2'b01 << rbuf_r)       : 2'b00;

  assign start_multiply = full_r[rbuf_r];
  assign buf_full       = full_r;
  assign len_err        = len_err_r;
  assign rd_valid       = rd_valid_r;

`ifdef S2MM_PP_LEN_CHECK_EN
  logic [MATRIXSIZE_W-1:0] batch_len_r, cur_len_s;
  assign cur_len_s = (beat_cnt_r == MATRIXSIZE_W'(0)) ? batch_beats : batch_len_r;
`endif

  // Batch termination and length-mismatch detection
  always_comb begin
    is_last_s = s_axis_s2mm_tlast;
    len_mis_s = 1'b0;
`ifdef S2MM_PP_LEN_CHECK_EN
    if (s_axis_s2mm_tlast) begin
      len_mis_s = (beat_cnt_r + MATRIXSIZE_W'(1)) != cur_len_s;
    end else if ((beat_cnt_r + MATRIXSIZE_W'(1)) == cur_len_s) begin
      len_mis_s = 1'b1;
      is_last_s = 1'b1;
    end else begin
      len_mis_s = 1'b0;
    end
`endif
  end

  // Reset-release delay for the input handshake
  always_ff @(posedge clk) begin
    rst_d_r <= rst;
  end

  // Input register, beat counter and ping-pong flags
  always_ff @(posedge clk) begin
    if (rst) begin
      wbuf_r       <= 1'b0;
      rbuf_r       <= 1'b0;
      full_r       <= 2'b00;
      beat_cnt_r   <= MATRIXSIZE_W'(0);
      wr_valid_r   <= 1'b0;
      wr_last_r    <= 1'b0;
      wr_buf_r     <= 1'b0;
      commit_r     <= 1'b0;
      commit_buf_r <= 1'b0;
      len_err_r    <= 1'b0;
      rd_valid_r   <= 1'b0;
    end else begin
      wr_valid_r <= accept_s;
      if (accept_s) begin
        wr_data_r <= s_axis_s2mm_tdata;
        wr_addr_r <= {wbuf_r, ADDR_W'(row_s % 32'(DEPTH))};
        wr_base_r <= 32'(bank_of(elem_idx_s, N));
        wr_last_r <= is_last_s;
        wr_buf_r  <= wbuf_r;
        if (is_last_s) begin
          beat_cnt_r <= MATRIXSIZE_W'(0);
          wbuf_r     <= ~wbuf_r;
        end else begin
          beat_cnt_r <= beat_cnt_r + MATRIXSIZE_W'(1);
        end
        if (ovf_s || len_mis_s) begin
          len_err_r <= 1'b1;
        end
      end
      commit_r     <= wr_valid_r && wr_last_r;
      commit_buf_r <= wr_buf_r;
      full_r       <= (full_r & ~clr_s) | set_s;
      if (release_s) begin
        rbuf_r <= ~rbuf_r;
      end
      rd_valid_r <= rd_en;
    end
  end

`ifdef S2MM_PP_LEN_CHECK_EN
  // Batch length captured on the first beat of each batch
  always_ff @(posedge clk) begin
    if (rst) begin
      batch_len_r <= MATRIXSIZE_W'(0);
    end else if (accept_s && (beat_cnt_r == MATRIXSIZE_W'(0))) begin
      batch_len_r <= batch_beats;
    end
  end
`endif

  // Beat groups start on a multiple of PACK, so bank k always takes lane k % PACK
  for (genvar k = 0; k < N; k++) begin : g_bank
    localparam int LANE = bank_of(k, PACK);
    localparam int GRP  = k - LANE;
    s2mm_bank_ram #(
      .D_W   (D_W),
      .AW    (ADDR_W + 1),
      .DEPTH2(2 * DEPTH)
    ) u_ram (
      .clk (clk),
      .rst (rst),
      .we  (wr_valid_r && (wr_base_r == 32'(GRP))),
      .wa  (wr_addr_r),
      .wd  (wr_data_r[LANE*D_W +: D_W]),
      .re  (rd_en),
      .ra  ({rbuf_r, rd_addr}),
      .q   (rd_data[k])
    );
  end

endmodule

// File: tb/tb_s2mm_pingpong.sv
// Directed self-checking bench for s2mm_pingpong with a row scoreboard.
module tb_s2mm_pingpong;
  localparam int D_W = 8, PACK = 2, N = 4, DEPTH = 1024, ADDR_W = 10, MW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst, tvalid, tlast, tready, start_multiply, done_multiply;
  logic                  rd_en, rd_valid, len_err;
  logic [PACK*D_W-1:0]   tdata;
  logic [MW-1:0]         batch_beats;
  logic [ADDR_W-1:0]     rd_addr;
  logic signed [D_W-1:0] rd_data [N];
  logic [1:0]            buf_full;

  int checks = 0, failures = 0, cyc = 0, stalls = 0;
  int tlast_cyc = 0, tlast_a = 0, rise_cyc = -100;
  logic start_prev = 1'b0;
  logic [N*D_W-1:0] exp_q [$];
  logic exp_len_err;

  s2mm_pingpong dut (
    .clk(clk), .rst(rst),
    .s_axis_s2mm_tdata(tdata), .s_axis_s2mm_tvalid(tvalid),
    .s_axis_s2mm_tlast(tlast), .s_axis_s2mm_tready(tready),
    .batch_beats(batch_beats), .start_multiply(start_multiply),
    .done_multiply(done_multiply), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .buf_full(buf_full), .len_err(len_err)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (start_multiply && !start_prev && rise_cyc < 0) rise_cyc = cyc;
    start_prev = start_multiply;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] elem(input logic [7:0] seed, input int idx);
    int x;
    x = idx ^ (idx >> 8);
    return 8'(seed + x[7:0]);
  endfunction

  task automatic push_row(input logic [7:0] seed, input int row);
    logic [N*D_W-1:0] e;
    for (int k = 0; k < N; k++) e[k*D_W +: D_W] = elem(seed, row * N + k);
    exp_q.push_back(e);
  endtask

  task automatic send_batch(input logic [7:0] seed, input int nbeats, input bit with_last);
    for (int j = 0; j < nbeats; j++) begin
      int w;
      tvalid = 1'b1;
      tdata  = {elem(seed, 2 * j + 1), elem(seed, 2 * j)};
      tlast  = with_last && (j == nbeats - 1);
      w = 0;
      while (!tready && w < 100) begin
        tick();
        w++;
        stalls++;
      end
      if (w >= 100) begin
        checks++;
        failures++;
        $error("FAIL tready_timeout observed=0 expected=1");
      end
      tick();
      if (tlast) tlast_cyc = cyc;
    end
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic read_row(input string tag, input logic [ADDR_W-1:0] a);
    logic [N*D_W-1:0] e;
    rd_en = 1'b1;
    rd_addr = a;
    tick();
    rd_en = 1'b0;
    chk({tag, "_valid"}, 32'(rd_valid), 32'd1);
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s_sb_empty observed=0 expected=1", tag);
    end else begin
      e = exp_q.pop_front();
      for (int k = 0; k < N; k++)
        chk($sformatf("%s_lane%0d", tag, k), {24'h0, rd_data[k]}, {24'h0, e[k*D_W +: D_W]});
    end
  endtask

  task automatic pulse_done();
    done_multiply = 1'b1;
    tick();
    done_multiply = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; tvalid = 1'b0; tlast = 1'b0; tdata = '0; batch_beats = 16'd4;
    done_multiply = 1'b0; rd_en = 1'b0; rd_addr = '0;
`ifdef S2MM_PP_LEN_CHECK_EN
    exp_len_err = 1'b1;
`else
    exp_len_err = 1'b0;
`endif
    // Reset release
    tick(); tick(); tick();
    chk("rst_tready", 32'(tready), 32'd0);
    chk("rst_start", 32'(start_multiply), 32'd0);
    chk("rst_buf_full", 32'(buf_full), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_len_err", 32'(len_err), 32'd0);
    for (int k = 0; k < N; k++) chk($sformatf("rst_lane%0d", k), {24'h0, rd_data[k]}, 32'd0);
    rst = 1'b0;
    chk("rst_d_tready", 32'(tready), 32'd0);
    tick();
    chk("post_rst_tready", 32'(tready), 32'd1);

    // Two back-to-back batches A (0..7) and B (negative values)
    push_row(8'h00, 0); push_row(8'h00, 1);
    push_row(8'hF0, 0); push_row(8'hF0, 1);
    stalls = 0;
    send_batch(8'h00, 4, 1'b1);
    tlast_a = tlast_cyc;
    send_batch(8'hF0, 4, 1'b1);
    chk("b2b_stalls", 32'(stalls), 32'd0);
    tick(); tick(); tick();
    chk("start_latency", 32'(rise_cyc - tlast_a), 32'd2);
    chk("both_full", 32'(buf_full), 32'd3);
    chk("start_hi", 32'(start_multiply), 32'd1);

    // Third batch stalls while both buffers are full
    tvalid = 1'b1;
    tdata  = {elem(8'h40, 1), elem(8'h40, 0)};
    tick(); tick();
    chk("c_stall", 32'(tready), 32'd0);
    read_row("a_r0", 10'd0);
    read_row("a_r1", 10'd1);
    tick();
    chk("idle_rd_valid", 32'(rd_valid), 32'd0);
    for (int k = 0; k < N; k++) chk($sformatf("idle_lane%0d", k), {24'h0, rd_data[k]}, 32'd0);
    done_multiply = 1'b1;
    chk("pre_release_tready", 32'(tready), 32'd0);
    tick();
    done_multiply = 1'b0;
    chk("release_tready", 32'(tready), 32'd1);
    tvalid = 1'b0;
    chk("release_buf_full", 32'(buf_full), 32'd2);
    chk("release_start", 32'(start_multiply), 32'd1);
    read_row("b_r0", 10'd0);
    read_row("b_r1", 10'd1);

    // Batch C into buffer 0, then release B so C becomes readable
    push_row(8'h40, 0); push_row(8'h40, 1);
    send_batch(8'h40, 4, 1'b1);
    tick(); tick(); tick();
    chk("c_full", 32'(buf_full), 32'd3);
    pulse_done();
    chk("c_release", 32'(buf_full), 32'd1);
    read_row("c_r0", 10'd0);
    read_row("c_r1", 10'd1);

    // Short batch: tlast on beat 3 with batch_beats=4
    send_batch(8'h60, 3, 1'b1);
    tick(); tick(); tick();
    chk("len_err_short", 32'(len_err), 32'(exp_len_err));
    chk("short_full", 32'(buf_full), 32'd3);

    // Drain both buffers, then check a done pulse with nothing ready is ignored
    pulse_done();
    pulse_done();
    chk("drained_full", 32'(buf_full), 32'd0);
    chk("drained_start", 32'(start_multiply), 32'd0);
    pulse_done();
    send_batch(8'h70, 4, 1'b1);
    tick(); tick(); tick();
    chk("ignored_done_start", 32'(start_multiply), 32'd1);
    chk("ignored_done_full", 32'(buf_full), 32'd1);

    // Reset mid-batch
    send_batch(8'h20, 2, 1'b0);
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick(); tick();
    chk("midrst_full", 32'(buf_full), 32'd0);
    chk("midrst_start", 32'(start_multiply), 32'd0);
    chk("midrst_len_err", 32'(len_err), 32'd0);
    push_row(8'h30, 0); push_row(8'h30, 1);
    send_batch(8'h30, 4, 1'b1);
    tick(); tick(); tick();
    chk("after_rst_full", 32'(buf_full), 32'd1);
    read_row("d_r0", 10'd0);
    read_row("d_r1", 10'd1);

    // Address overflow: 2050 beats wrap row 1024 onto row 0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    batch_beats = 16'd2050;
    push_row(8'h55, 1024); push_row(8'h55, 1);
    send_batch(8'h55, 2050, 1'b1);
    tick(); tick(); tick();
    chk("ovf_len_err", 32'(len_err), 32'd1);
    chk("ovf_full", 32'(buf_full), 32'd1);
    read_row("ovf_r0", 10'd0);
    read_row("ovf_r1", 10'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
